// File: rtl/rggen_register_access_sequencer.sv
// Host-side request sequencer: broadcasts one access to all register instances and holds a registered response until accepted.
// Response 2 cycles after handshake (1 when out of range); optional BUSY timeout via RGGEN_ACCESS_TIMEOUT_EN.
module rggen_register_access_sequencer #(
  parameter int                     ADDRESS_WIDTH  = 8,
  parameter int                     BUS_WIDTH      = 32,
  parameter int                     REGISTERS      = 1,
  parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS   = '0,
  parameter int                     BYTE_SIZE      = 256,
  parameter int                     TIMEOUT_CYCLES = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_request_valid,
  output logic                                  o_request_ready,
  input  logic [1:0]                            i_request_access,
  input  logic [ADDRESS_WIDTH-1:0]              i_request_address,
  input  logic [BUS_WIDTH-1:0]                  i_request_write_data,
  input  logic [BUS_WIDTH/8-1:0]                i_request_strobe,
  output logic                                  o_response_valid,
  input  logic                                  i_response_ready,
  output logic [1:0]                            o_response_status,
  output logic [BUS_WIDTH-1:0]                  o_response_read_data,
  output logic                                  o_register_valid,
  output logic [1:0]                            o_register_access,
  output logic [ADDRESS_WIDTH-1:0]              o_register_address,
  output logic [BUS_WIDTH-1:0]                  o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]                o_register_strobe,
  input  logic [REGISTERS-1:0]                  i_register_active,
  input  logic [REGISTERS-1:0]                  i_register_ready,
  input  logic [REGISTERS-1:0][1:0]             i_register_status,
  input  logic [REGISTERS-1:0][BUS_WIDTH-1:0]   i_register_read_data
);

  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int WORD_LSB = $clog2(STRB_W);
  localparam int RGGEN_ACCESS_DATA_BIT = 0;
  localparam logic [1:0] RGGEN_OKAY         = 2'b00;
  localparam logic [1:0] RGGEN_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] RGGEN_DECODE_ERROR = 2'b11;
  localparam bit [ADDRESS_WIDTH:0]   BLOCK_BEGIN = {1'b0, BASE_ADDRESS};
  localparam bit [ADDRESS_WIDTH:0]   BLOCK_SIZE  = (ADDRESS_WIDTH + 1)'(BYTE_SIZE);
  localparam bit [ADDRESS_WIDTH-1:0] WORD_MASK   = {ADDRESS_WIDTH{1'b1}} << WORD_LSB;

  if ((BUS_WIDTH % 8) != 0 || REGISTERS < 1 || TIMEOUT_CYCLES < 1) begin : g_config_error
    $error("rggen_register_access_sequencer: invalid parameter set");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPONSE
  } state_e;

  state_e                   state_q;
  logic                     request_ready_q;
  logic                     response_valid_q;
  logic                     register_valid_q;
  logic [1:0]               response_status_q;
  logic [BUS_WIDTH-1:0]     response_read_data_q;
  logic [1:0]               access_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     write_data_q;
  logic [STRB_W-1:0]        strobe_q;

  logic [ADDRESS_WIDTH:0]   request_offset;
  logic                     request_in_range;
  logic                     is_write;
  logic                     any_active;
  logic                     any_ready;
  logic [1:0]               collected_status;
  logic [BUS_WIDTH-1:0]     collected_read_data;
  logic                     timeout_expired;

  // Addresses below the base wrap to a huge offset, so one compare covers both bounds.
  assign request_offset   = {1'b0, i_request_address} - BLOCK_BEGIN;
  assign request_in_range = request_offset < BLOCK_SIZE;
  assign is_write         = access_q[RGGEN_ACCESS_DATA_BIT];

  always_comb begin
    any_active          = 1'b0;
    any_ready           = 1'b0;
    collected_status    = '0;
    collected_read_data = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (i_register_active[i]) begin
        any_active          = 1'b1;
        any_ready           = any_ready | i_register_ready[i];
        collected_status    = collected_status | i_register_status[i];
        collected_read_data = collected_read_data | i_register_read_data[i];
      end
    end
  end

`ifdef RGGEN_ACCESS_TIMEOUT_EN
  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMEOUT_W-1:0] timeout_count_q;

  assign timeout_expired = timeout_count_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      timeout_count_q <= '0;
    end else if (state_q != BUSY) begin
      timeout_count_q <= '0;
    end else if (!any_ready) begin
      timeout_count_q <= timeout_count_q + TIMEOUT_W'(1);
    end
  end
`else
  assign timeout_expired = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q              <= IDLE;
      request_ready_q      <= 1'b1;
      response_valid_q     <= 1'b0;
      register_valid_q     <= 1'b0;
      response_status_q    <= RGGEN_OKAY;
      response_read_data_q <= '0;
      access_q             <= '0;
      address_q            <= '0;
      write_data_q         <= '0;
      strobe_q             <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_request_valid) begin
            access_q        <= i_request_access;
            address_q       <= i_request_address;
            write_data_q    <= i_request_write_data;
            strobe_q        <= i_request_strobe;
            request_ready_q <= 1'b0;
            if (request_in_range) begin
              register_valid_q <= 1'b1;
              state_q          <= BUSY;
            end else begin
              response_status_q    <= RGGEN_DECODE_ERROR;
              response_read_data_q <= '0;
              response_valid_q     <= 1'b1;
              state_q              <= RESPONSE;
            end
          end
        end
        BUSY: begin
          if (!any_active || any_ready || timeout_expired) begin
            register_valid_q <= 1'b0;
            response_valid_q <= 1'b1;
            state_q          <= RESPONSE;
            if (!any_active) begin
              response_status_q    <= RGGEN_DECODE_ERROR;
              response_read_data_q <= '0;
            end else if (any_ready) begin
              response_status_q    <= collected_status;
              response_read_data_q <= is_write ? '0 : collected_read_data;
            end else begin
              response_status_q    <= RGGEN_SLAVE_ERROR;
              response_read_data_q <= '0;
            end
          end
        end
        RESPONSE: begin
          if (i_response_ready) begin
            response_valid_q <= 1'b0;
            request_ready_q  <= 1'b1;
            state_q          <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_request_ready       = request_ready_q;
  assign o_response_valid      = response_valid_q;
  assign o_response_status     = response_status_q;
  assign o_response_read_data  = response_read_data_q;
  assign o_register_valid      = register_valid_q;
  assign o_register_access     = access_q;
  assign o_register_address    = address_q & WORD_MASK;
  assign o_register_write_data = is_write ? write_data_q : '0;
  assign o_register_strobe     = is_write ? strobe_q : '0;

endmodule

// File: tb/tb_rggen_register_access_sequencer.sv
// Bench for rggen_register_access_sequencer: expected responses queued at issue, compared when the response appears.
module tb_rggen_register_access_sequencer;

  localparam int AW = 16;
  localparam int BW = 32;
  localparam int NR = 2;
  localparam int TO = 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] RD     = 2'b10;
  localparam logic [1:0] WR     = 2'b11;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    req_vld = 1'b0;
  logic                    req_rdy;
  logic [1:0]              req_acc = '0;
  logic [AW-1:0]           req_addr = '0;
  logic [BW-1:0]           req_wdat = '0;
  logic [BW/8-1:0]         req_strb = '0;
  logic                    rsp_vld;
  logic                    rsp_rdy = 1'b0;
  logic [1:0]              rsp_status;
  logic [BW-1:0]           rsp_dat;
  logic                    reg_vld;
  logic [1:0]              reg_acc;
  logic [AW-1:0]           reg_addr;
  logic [BW-1:0]           reg_wdat;
  logic [BW/8-1:0]         reg_strb;
  logic [NR-1:0]           act = '0;
  logic [NR-1:0]           rdy = '0;
  logic [NR-1:0][1:0]      st = '0;
  logic [NR-1:0][BW-1:0]   rdat = '0;

  typedef struct packed {
    logic [1:0]    status;
    logic [BW-1:0] dat;
  } rsp_t;

  rsp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  rggen_register_access_sequencer #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .REGISTERS     (NR),
    .BASE_ADDRESS  ('0),
    .BYTE_SIZE     (256),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_request_valid      (req_vld),
    .o_request_ready      (req_rdy),
    .i_request_access     (req_acc),
    .i_request_address    (req_addr),
    .i_request_write_data (req_wdat),
    .i_request_strobe     (req_strb),
    .o_response_valid     (rsp_vld),
    .i_response_ready     (rsp_rdy),
    .o_response_status    (rsp_status),
    .o_response_read_data (rsp_dat),
    .o_register_valid     (reg_vld),
    .o_register_access    (reg_acc),
    .o_register_address   (reg_addr),
    .o_register_write_data(reg_wdat),
    .o_register_strobe    (reg_strb),
    .i_register_active    (act),
    .i_register_ready     (rdy),
    .i_register_status    (st),
    .i_register_read_data (rdat)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one request; the handshake edge is the posedge inside this task.
  task automatic issue(input logic [1:0] acc, input logic [AW-1:0] addr,
                       input logic [BW-1:0] wd, input logic [BW/8-1:0] strb);
    @(negedge clk);
    check_eq("req_rdy_idle", req_rdy, 1'b1);
    req_vld  = 1'b1;
    req_acc  = acc;
    req_addr = addr;
    req_wdat = wd;
    req_strb = strb;
    @(posedge clk);
    #1 req_vld = 1'b0;
  endtask

  task automatic accept();
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    check_eq("rsp_vld_after_accept", rsp_vld, 1'b0);
    check_eq("req_rdy_after_accept", req_rdy, 1'b1);
  endtask

  task automatic compare_response(input string tag);
    rsp_t e;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check_eq({tag, "_status"}, rsp_status, e.status);
    check_eq({tag, "_data"}, rsp_dat, e.dat);
  endtask

  // Full access with the bench's own model of the expected result and timing.
  task automatic access(input string tag, input logic [1:0] acc, input logic [AW-1:0] addr,
                        input logic [BW-1:0] wd, input logic [BW/8-1:0] strb, input int hold);
    rsp_t          e;
    int            exp_lat;
    int            exp_v;
    int            lat;
    int            vcnt;
    logic [1:0]    st_or;
    logic [BW-1:0] rd_or;
    st_or = '0;
    rd_or = '0;
    for (int i = 0; i < NR; i++) begin
      if (act[i]) begin
        st_or = st_or | st[i];
        rd_or = rd_or | rdat[i];
      end
    end
    if (addr >= 16'h0100) begin
      e = '{DECERR, '0}; exp_lat = 1; exp_v = 0;
    end else if (act == '0) begin
      e = '{DECERR, '0}; exp_lat = 2; exp_v = 1;
    end else if ((act & rdy) == '0) begin
      e = '{SLVERR, '0}; exp_lat = TO + 1; exp_v = TO;
    end else begin
      e.status = st_or;
      e.dat    = acc[0] ? '0 : rd_or;
      exp_lat  = 2; exp_v = 1;
    end
    sb_q.push_back(e);
    issue(acc, addr, wd, strb);
    lat  = 0;
    vcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (reg_vld) begin
        vcnt++;
        if (vcnt == 1) begin
          check_eq({tag, "_reg_acc"}, reg_acc, acc);
          check_eq({tag, "_reg_addr"}, reg_addr, addr & 16'hFFFC);
          check_eq({tag, "_reg_wdat"}, reg_wdat, acc[0] ? wd : '0);
          check_eq({tag, "_reg_strb"}, reg_strb, acc[0] ? strb : '0);
        end
      end
      if (rsp_vld) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_reg_vld_cycles"}, vcnt, exp_v);
    if (lat == 0) begin
      void'(sb_q.pop_front());
      return;
    end
    compare_response(tag);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq({tag, "_hold_vld"}, rsp_vld, 1'b1);
      check_eq({tag, "_hold_status"}, rsp_status, e.status);
      check_eq({tag, "_hold_data"}, rsp_dat, e.dat);
      check_eq({tag, "_hold_req_rdy"}, req_rdy, 1'b0);
    end
    accept();
  endtask

  initial begin
    int n;
    int lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_rdy", req_rdy, 1'b1);
    check_eq("rst_rsp_vld", rsp_vld, 1'b0);
    check_eq("rst_rsp_status", rsp_status, OKAY);
    check_eq("rst_rsp_data", rsp_dat, 0);
    check_eq("rst_reg_vld", reg_vld, 1'b0);
    check_eq("rst_reg_addr", reg_addr, 0);
    check_eq("rst_reg_acc", reg_acc, 0);
    rst_n = 1'b1;

    act = 2'b10; rdy = 2'b10; rdat[1] = 32'h1234_5678;
    access("wr04", WR, 16'h0004, 32'hDEAD_BEEF, 4'hF, 0);
    access("rd06", RD, 16'h0006, 32'hFFFF_FFFF, 4'hF, 5);
    access("rd100", RD, 16'h0100, 32'h0, 4'h0, 0);
    access("wr_part", WR, 16'h0013, 32'h0BAD_F00D, 4'h6, 1);

    act = 2'b00; rdy = 2'b00;
    access("rd20_noact", RD, 16'h0020, 32'h0, 4'h0, 0);

    act = 2'b11; rdy = 2'b01;
    rdat[0] = 32'h0F00_0000; rdat[1] = 32'h0000_00F0;
    st[0] = OKAY; st[1] = SLVERR;
    access("rd_or_ff", RD, 16'h00FF, 32'h0, 4'h0, 2);
    st = '0;

`ifdef RGGEN_ACCESS_TIMEOUT_EN
    act = 2'b10; rdy = 2'b00;
    access("timeout", RD, 16'h0030, 32'h0, 4'h0, 0);

    rdat[1] = 32'hA5A5_5A5A;
    sb_q.push_back('{OKAY, 32'hA5A5_5A5A});
    issue(RD, 16'h0008, 32'h0, 4'h0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == TO) rdy = 2'b10;
      if (rsp_vld) begin
        lat = k;
        break;
      end
    end
    check_eq("expiry_ready_latency", lat, TO + 1);
    compare_response("expiry_ready");
    rdy = 2'b00;
    accept();
    n = TO - 1;
`else
    n = 100;
`endif

    act = 2'b10; rdy = 2'b00;
    issue(RD, 16'h0010, 32'h0, 4'h0);
    repeat (n) @(negedge clk);
    check_eq("stall_reg_vld", reg_vld, 1'b1);
    check_eq("stall_rsp_vld", rsp_vld, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("busy_rst_reg_vld", reg_vld, 1'b0);
    check_eq("busy_rst_req_rdy", req_rdy, 1'b1);
    check_eq("busy_rst_rsp_vld", rsp_vld, 1'b0);
    rst_n = 1'b1;

    rdy = 2'b10; rdat[1] = 32'hCAFE_F00D;
    access("post_rst_rd", RD, 16'h0010, 32'h0, 4'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rggen_register_access_sequencer.md
# rggen_register_access_sequencer

Host-side front stage of the register block. It accepts one bus request at a time from a protocol adapter and broadcasts it to all `rggen_register_common` instances. It then collects their `active`/`ready`/`status`/`read_data` returns and holds a registered response until the host accepts it. Decode errors and, optionally, stalled accesses are resolved here so that register instances never see them.

## Interface
- `ADDRESS_WIDTH`, 8: byte address width.
- `BUS_WIDTH`, 32: data width; must be a multiple of 8.
- `REGISTERS`, 1: number of attached register instances; must be ≥1.
- `BASE_ADDRESS`, '0: first byte address of the block.
- `BYTE_SIZE`, 256: block size in bytes.
- `TIMEOUT_CYCLES`, 16: BUSY cycles allowed before timeout. Only used with `RGGEN_ACCESS_TIMEOUT_EN`; must be ≥1.
- `i_clk` input 1: clock; the single clock of the block.
- `i_rst_n` input 1: reset, synchronous, active-low.
- `i_request_valid` input 1: host request valid.
- `o_request_ready` output 1: request accepted when high together with `i_request_valid`.
- `i_request_access` input 2: `rggen_access`; bit `RGGEN_ACCESS_DATA_BIT` set means write.
- `i_request_address` input ADDRESS_WIDTH: byte address.
- `i_request_write_data` input BUS_WIDTH: write data.
- `i_request_strobe` input BUS_WIDTH/8: byte strobes.
- `o_response_valid` output 1: response valid.
- `i_response_ready` input 1: host accepts the response.
- `o_response_status` output 2: `rggen_status`.
- `o_response_read_data` output BUS_WIDTH: read data.
- `register_if[REGISTERS]`: `rggen_register_if.host`, a broadcast request with per-instance `active`/`ready`/`status`/`read_data`.

## Operation
- States: IDLE, BUSY, RESPONSE.
- IDLE:
  - `o_request_ready`=1.
  - On handshake, capture access, address, write data and strobe into the request register.
  - If the address is outside [BASE_ADDRESS, BASE_ADDRESS+BYTE_SIZE), load response {`RGGEN_DECODE_ERROR`, data 0} and go to RESPONSE.
  - Otherwise go to BUSY.
- BUSY:
  - All `register_if[i].valid`=1.
  - `address` is the captured address with its low $clog2(BUS_WIDTH/8) bits zeroed.
  - On reads, `write_data` and `strobe` are forced to 0.
  - If no `active[i]`: load {`RGGEN_DECODE_ERROR`, 0} and go to RESPONSE.
  - Else, if any `ready[i]` and `active[i]`: load the OR of `status[i]` and the OR of `read_data[i]` over active instances, then go to RESPONSE. Reads load the collected data; writes load 0.
  - Else stay in BUSY.
- RESPONSE:
  - `o_response_valid`=1, and the response register stays stable.
  - On `i_response_ready`, go to IDLE.
- `o_request_ready` is high only in IDLE. A request arriving while a response is being accepted waits until the following cycle.
- More than one active instance is a configuration error. Results are OR-combined, not arbitrated.

## Timing
- Reset values: state=IDLE, `o_request_ready`=1, `o_response_valid`=0, `o_response_status`=`RGGEN_OKAY`, `o_response_read_data`=0, all `register_if.valid`=0, request register=0, timeout counter=0.
- Reset asserted in any state returns to IDLE at the next edge. Any pending response is discarded.
- In-range access, ready on the first BUSY cycle:
  - handshake at edge N;
  - `register_if.valid` during cycle N+1;
  - `o_response_valid` from N+2.
- Out-of-range access: `o_response_valid` from N+1; `register_if.valid` is never asserted.
- Throughput: at most one access per 3 cycles.
- `o_response_*` are driven from flops only. There is no combinational path from `register_if` to the host outputs.

## Configuration
- `RGGEN_ACCESS_TIMEOUT_EN` defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on BUSY entry and increments every BUSY cycle without ready.
  - When it reaches TIMEOUT_CYCLES-1 and ready is still low, load {`RGGEN_SLAVE_ERROR`, 0}, deassert `valid` and go to RESPONSE.
  - Ready in the same cycle as expiry wins, and the normal response is loaded.
- `RGGEN_ACCESS_TIMEOUT_EN` undefined: no counter, and BUSY waits indefinitely for ready.

## Test plan
- Write 0xDEADBEEF, strobe 0xF, to address 0x04 with instance 1 active and ready → `register_if.valid` for 1 cycle with address 0x04 and strobe 0xF; response at N+2 with `RGGEN_OKAY`, data 0.
- Read 0x06 with instance 1 returning 0x12345678 → address presented as 0x04; response {`RGGEN_OKAY`, 0x12345678}, stable while `i_response_ready` is held low for 5 cycles.
- Read 0x100 with BYTE_SIZE=256 → no `register_if.valid`; response at N+1 with `RGGEN_DECODE_ERROR`, data 0.
- In-range read 0x20 with no instance active → response {`RGGEN_DECODE_ERROR`, 0} at N+2.
- Timeout build, TIMEOUT_CYCLES=4, instance active but never ready → `valid` high for 4 cycles, then {`RGGEN_SLAVE_ERROR`, 0}. Non-timeout build → still BUSY after 100 cycles.
- Reset pulled low in BUSY → next cycle IDLE, `valid`=0, `o_request_ready`=1; a subsequent read completes normally.
